// File: rtl/lifo_fifo_buffer_if.sv
// Producer/consumer side of the dual-mode buffer: strobes, data, status and error flags.
`timescale 1ns/1ps
interface lifo_fifo_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic              clear;
  logic              fifo_mode;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              val;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [LW-1:0]     level;
  logic              mode;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport master (
    output clear, fifo_mode, push, pop, data_in, err_clr,
    input  data_out, val, full, almost_full, almost_empty, level, mode, overflow, underflow
  );

  modport slave (
    input  clear, fifo_mode, push, pop, data_in, err_clr,
    output data_out, val, full, almost_full, almost_empty, level, mode, overflow, underflow
  );
endinterface

// File: rtl/lifo_fifo_buffer.sv
// One register array used as a stack or a queue; the mode is latched while the buffer holds data.
`timescale 1ns/1ps
module lifo_fifo_buffer #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lifo_fifo_buffer_if.slave    bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LW-1:0]     level_q, level_d;
  logic [PW-1:0]     rd_ptr, rd_d, wr_ptr, wr_d;
  logic [PW-1:0]     wr_idx, top_idx;
  logic              wr_en, set_ovf, set_unf;
  logic              mode_q, mode, is_val, is_full;
  logic              overflow_q, underflow_q;

  // Pointers wrap by compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign is_val  = (level_q != '0);
  assign is_full = (level_q == LW'(DEPTH));
  assign mode    = is_val ? mode_q : bus.fifo_mode;
  assign top_idx = PW'(level_q - LW'(1));

  always_comb begin
    level_d = level_q;
    rd_d    = rd_ptr;
    wr_d    = wr_ptr;
    wr_en   = 1'b0;
    wr_idx  = wr_ptr;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (bus.clear) begin
      level_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else if (bus.push && bus.pop && is_val) begin
      wr_en = 1'b1;
      if (mode) begin
        wr_d = ptr_inc(wr_ptr);
        rd_d = ptr_inc(rd_ptr);
      end else begin
        wr_idx = top_idx;
      end
    end else if (bus.push) begin
      // A pop alongside a push into an empty buffer is dropped but still flagged.
      set_unf = bus.pop;
      if (is_full) begin
        set_ovf = 1'b1;
      end else begin
        wr_en   = 1'b1;
        level_d = level_q + LW'(1);
        if (mode) wr_d = ptr_inc(wr_ptr);
        else      wr_idx = PW'(level_q);
      end
    end else if (bus.pop) begin
      if (is_val) begin
        level_d = level_q - LW'(1);
        if (mode) rd_d = ptr_inc(rd_ptr);
      end else begin
        set_unf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      mode_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      rd_ptr      <= rd_d;
      wr_ptr      <= wr_d;
      mode_q      <= mode;
      overflow_q  <= set_ovf | (overflow_q & ~bus.err_clr);
      underflow_q <= set_unf | (underflow_q & ~bus.err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= bus.data_in;
  end

  assign bus.data_out     = !is_val ? '0 : (mode_q ? mem[rd_ptr] : mem[top_idx]);
  assign bus.val          = is_val;
  assign bus.full         = is_full;
  assign bus.almost_full  = (level_q >= LW'(AF_LEVEL));
  assign bus.almost_empty = (level_q <= LW'(AE_LEVEL));
  assign bus.level        = level_q;
  assign bus.mode         = mode;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Directed bench: a default-threshold buffer and a second one with AF_LEVEL=6/AE_LEVEL=2 share stimulus.
`timescale 1ns/1ps
module tb_lifo_fifo_buffer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  lifo_fifo_buffer_if #(.DEPTH(8), .DATA_W(8)) bus_a ();
  lifo_fifo_buffer_if #(.DEPTH(8), .DATA_W(8)) bus_b ();

  lifo_fifo_buffer #(.DEPTH(8), .DATA_W(8)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  lifo_fifo_buffer #(.DEPTH(8), .DATA_W(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  assign bus_b.clear     = bus_a.clear;
  assign bus_b.fifo_mode = bus_a.fifo_mode;
  assign bus_b.push      = bus_a.push;
  assign bus_b.pop       = bus_a.pop;
  assign bus_b.data_in   = bus_a.data_in;
  assign bus_b.err_clr   = bus_a.err_clr;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of strobes; outputs are sampled 1ns after the edge.
  task automatic applyStimulus(input logic p, input logic q, input logic [7:0] d);
    bus_a.push    = p;
    bus_a.pop     = q;
    bus_a.data_in = d;
    @(posedge clk);
    #1;
    bus_a.push = 1'b0;
    bus_a.pop  = 1'b0;
  endtask

  initial begin
    logic [7:0] fifo_exp [8];
    int lvl;
    fifo_exp = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0B};

    bus_a.clear     = 1'b0;
    bus_a.fifo_mode = 1'b0;
    bus_a.push      = 1'b0;
    bus_a.pop       = 1'b0;
    bus_a.data_in   = 8'h00;
    bus_a.err_clr   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    bus_a.fifo_mode = 1'b1;
    #1;
    checkOutput("rst_mode_follows", bus_a.mode, 1);
    bus_a.fifo_mode = 1'b0;
    reset_n = 1'b1;
    applyStimulus(0, 0, 8'h00);
    checkOutput("rst_level", bus_a.level, 0);
    checkOutput("rst_val", bus_a.val, 0);
    checkOutput("rst_full", bus_a.full, 0);
    checkOutput("rst_af", bus_a.almost_full, 0);
    checkOutput("rst_ae", bus_a.almost_empty, 1);
    checkOutput("rst_dout", bus_a.data_out, 0);
    checkOutput("rst_ovf", bus_a.overflow, 0);
    checkOutput("rst_unf", bus_a.underflow, 0);
    checkOutput("rst_mode", bus_a.mode, 0);

    // LIFO ordering and underflow
    applyStimulus(1, 0, 8'h11);
    checkOutput("lifo_push1", bus_a.data_out, 8'h11);
    applyStimulus(1, 0, 8'h22);
    checkOutput("lifo_push2", bus_a.data_out, 8'h22);
    applyStimulus(1, 0, 8'h33);
    checkOutput("lifo_push3", bus_a.data_out, 8'h33);
    checkOutput("lifo_lvl3", bus_a.level, 3);
    applyStimulus(0, 1, 8'h00);
    checkOutput("lifo_pop1", bus_a.data_out, 8'h22);
    checkOutput("lifo_lvl2", bus_a.level, 2);
    applyStimulus(0, 1, 8'h00);
    checkOutput("lifo_pop2", bus_a.data_out, 8'h11);
    applyStimulus(0, 1, 8'h00);
    checkOutput("lifo_pop3", bus_a.data_out, 8'h00);
    checkOutput("lifo_empty_val", bus_a.val, 0);
    checkOutput("lifo_pre_unf", bus_a.underflow, 0);
    applyStimulus(0, 1, 8'h00);
    checkOutput("lifo_unf", bus_a.underflow, 1);
    checkOutput("lifo_unf_lvl", bus_a.level, 0);
    bus_a.err_clr = 1'b1;
    applyStimulus(0, 0, 8'h00);
    bus_a.err_clr = 1'b0;
    checkOutput("errclr_unf", bus_a.underflow, 0);

    // FIFO with wrap, full, overflow and push+pop at full
    bus_a.fifo_mode = 1'b1;
    #1;
    checkOutput("fifo_mode_empty", bus_a.mode, 1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 0, 8'(i));
      checkOutput("fifo_head01", bus_a.data_out, 8'h01);
    end
    applyStimulus(0, 1, 8'h00);
    checkOutput("fifo_pop01", bus_a.data_out, 8'h02);
    checkOutput("fifo_lvl3", bus_a.level, 3);
    for (int i = 5; i <= 9; i++) applyStimulus(1, 0, 8'(i));
    checkOutput("fifo_lvl8", bus_a.level, 8);
    checkOutput("fifo_full", bus_a.full, 1);
    checkOutput("fifo_no_ovf", bus_a.overflow, 0);
    applyStimulus(1, 0, 8'h0A);
    checkOutput("fifo_ovf", bus_a.overflow, 1);
    checkOutput("fifo_ovf_lvl", bus_a.level, 8);
    checkOutput("fifo_ovf_head", bus_a.data_out, 8'h02);
    bus_a.err_clr = 1'b1;
    applyStimulus(0, 0, 8'h00);
    bus_a.err_clr = 1'b0;
    checkOutput("errclr_ovf", bus_a.overflow, 0);
    applyStimulus(1, 1, 8'h0B);
    checkOutput("fifo_pp_head", bus_a.data_out, 8'h03);
    checkOutput("fifo_pp_lvl", bus_a.level, 8);
    checkOutput("fifo_pp_ovf", bus_a.overflow, 0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("fifo_drain", bus_a.data_out, 32'(fifo_exp[k]));
      applyStimulus(0, 1, 8'h00);
    end
    checkOutput("fifo_drained_lvl", bus_a.level, 0);
    checkOutput("fifo_drained_dout", bus_a.data_out, 0);

    // LIFO fill with threshold reporting on both instances
    bus_a.fifo_mode = 1'b0;
    #1;
    checkOutput("lifo_mode_empty", bus_a.mode, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 8'hA0 + 8'(k));
      lvl = k + 1;
      checkOutput("fill_lvl", bus_a.level, 32'(lvl));
      checkOutput("fill_top", bus_a.data_out, 32'(8'hA0 + 8'(k)));
      checkOutput("fill_ae_a", bus_a.almost_empty, 32'(lvl <= 1));
      checkOutput("fill_af_a", bus_a.almost_full, 32'(lvl >= 7));
      checkOutput("fill_ae_b", bus_b.almost_empty, 32'(lvl <= 2));
      checkOutput("fill_af_b", bus_b.almost_full, 32'(lvl >= 6));
    end
    checkOutput("lifo_full", bus_a.full, 1);
    applyStimulus(1, 1, 8'hEE);
    checkOutput("lifo_pp_top", bus_a.data_out, 8'hEE);
    checkOutput("lifo_pp_lvl", bus_a.level, 8);
    checkOutput("lifo_pp_ovf", bus_a.overflow, 0);
    applyStimulus(0, 1, 8'h00);
    checkOutput("lifo_pp_pop", bus_a.data_out, 8'hA6);
    checkOutput("lifo_lvl7", bus_a.level, 7);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 8'h00);
    checkOutput("lifo_lvl3b", bus_a.level, 3);
    checkOutput("lifo_top_a2", bus_a.data_out, 8'hA2);

    // Mode request ignored while data is held
    bus_a.fifo_mode = 1'b1;
    #1;
    checkOutput("mode_held", bus_a.mode, 0);
    applyStimulus(0, 0, 8'h00);
    checkOutput("mode_held_idle", bus_a.mode, 0);
    applyStimulus(0, 1, 8'h00);
    checkOutput("mode_pop_a1", bus_a.data_out, 8'hA1);
    applyStimulus(0, 1, 8'h00);
    checkOutput("mode_pop_a0", bus_a.data_out, 8'hA0);
    applyStimulus(0, 1, 8'h00);
    checkOutput("mode_drained_lvl", bus_a.level, 0);
    checkOutput("mode_follows", bus_a.mode, 1);

    // Push+pop on empty, clear preserving flags, err_clr set-wins
    applyStimulus(1, 1, 8'h55);
    checkOutput("pp_empty_lvl", bus_a.level, 1);
    checkOutput("pp_empty_dout", bus_a.data_out, 8'h55);
    checkOutput("pp_empty_unf", bus_a.underflow, 1);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 8'h56 + 8'(k));
    checkOutput("clr_pre_lvl", bus_a.level, 5);
    checkOutput("clr_pre_head", bus_a.data_out, 8'h55);
    checkOutput("clr_pre_ae_b", bus_b.almost_empty, 0);
    bus_a.clear = 1'b1;
    applyStimulus(1, 0, 8'h60);
    bus_a.clear = 1'b0;
    checkOutput("clr_lvl", bus_a.level, 0);
    checkOutput("clr_val", bus_a.val, 0);
    checkOutput("clr_dout", bus_a.data_out, 0);
    checkOutput("clr_unf_kept", bus_a.underflow, 1);
    applyStimulus(1, 0, 8'h61);
    checkOutput("clr_push", bus_a.data_out, 8'h61);
    checkOutput("clr_push_lvl", bus_a.level, 1);
    applyStimulus(0, 1, 8'h00);
    bus_a.err_clr = 1'b1;
    applyStimulus(0, 0, 8'h00);
    checkOutput("errclr_unf2", bus_a.underflow, 0);
    applyStimulus(0, 1, 8'h00);
    bus_a.err_clr = 1'b0;
    checkOutput("errclr_set_wins", bus_a.underflow, 1);

    // Asynchronous reset mid-operation
    bus_a.fifo_mode = 1'b0;
    applyStimulus(1, 0, 8'h71);
    applyStimulus(1, 0, 8'h72);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_lvl", bus_a.level, 0);
    checkOutput("async_rst_dout", bus_a.data_out, 0);
    checkOutput("async_rst_unf", bus_a.underflow, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1, 0, 8'h77);
    checkOutput("post_rst_push", bus_a.data_out, 8'h77);
    checkOutput("post_rst_lvl", bus_a.level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lifo_fifo_buffer.md
# lifo_fifo_buffer

Parametrised dual-mode storage buffer, the successor to the team's fixed-mode LIFO buffer. One register array serves as a stack (LIFO) or a queue (FIFO), selected at run time. The mode may change only while the buffer is empty. The block adds level and almost-full/almost-empty reporting, sticky overflow/underflow error flags and a synchronous clear. It sits between a producer and a consumer that use simple push/pop strobes with no back-pressure handshake beyond the status flags.

## Interface
- DEPTH, 8: number of entries, ≥2; need not be a power of two.
- DATA_W, 8: entry width in bits.
- AF_LEVEL, DEPTH-1: almost_full asserts when level ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1: almost_empty asserts when level ≤ AE_LEVEL (0..DEPTH-1).
- LW = $clog2(DEPTH+1): level width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush (level/pointers to 0).
- fifo_mode  in  1  requested mode: 0 = LIFO, 1 = FIFO.
- push  in  1  write data_in this cycle.
- pop  in  1  consume the entry on data_out this cycle.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  current top (LIFO) or head (FIFO); 0 when empty.
- val  out  1  level ≠ 0.
- full  out  1  level == DEPTH.
- almost_full  out  1  level ≥ AF_LEVEL.
- almost_empty  out  1  level ≤ AE_LEVEL.
- level  out  LW  current occupancy.
- mode  out  1  effective mode this cycle.
- overflow  out  1  sticky: push rejected because full.
- underflow  out  1  sticky: pop while empty.
- err_clr  in  1  synchronous clear of overflow/underflow.

## Operation
- Effective mode: mode = (level==0) ? fifo_mode : mode_q. mode_q <= mode every cycle. A fifo_mode change while non-empty is ignored until the buffer drains.
- Storage: mem[0..DEPTH-1]. LIFO top index = level-1. FIFO uses rd_ptr/wr_ptr, each wrapping from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
- Priority each edge: reset_n low > clear > push/pop.
- clear: level, rd_ptr and wr_ptr go to 0. Push/pop in the same cycle are ignored. Flags are unchanged. mem contents are don't-care.
- push only, not full: LIFO writes mem[level]; FIFO writes mem[wr_ptr] and advances wr_ptr. level+1.
- push only, full: no write, level unchanged, overflow <= 1.
- pop only, val: LIFO level-1; FIFO advances rd_ptr and level-1.
- pop only, empty: no change, underflow <= 1.
- push+pop, val (includes full): LIFO overwrites mem[level-1] with data_in (replace top). FIFO writes mem[wr_ptr] and advances both pointers. level unchanged, no overflow.
- push+pop, empty: the push is performed (level becomes 1), the pop is ignored, underflow <= 1.
- err_clr: clears both sticky flags. If a new error occurs in the same cycle, the flag sets (set wins).
- Status outputs (val, full, almost_*, level, data_out) are combinational from registered state only. There is no combinational path from push/pop/data_in to any output.
- level arithmetic in LW bits; it never exceeds DEPTH and never goes below 0.

## Timing
- Reset values (asynchronous assertion, synchronous-safe release): level 0, val 0, full 0, almost_full 0, almost_empty 1, mode_q 0, mode = fifo_mode, overflow 0, underflow 0, data_out 0, pointers 0.
- Write-to-read latency: 1 cycle. Data pushed at edge N is on data_out after edge N when it is top/head.
- Pop effect: data_out shows the next entry after the edge that consumed the pop.
- Flags update on the same edge as the offending operation and are visible in the following cycle.
- Reset asserted mid-operation: all state is lost immediately. The first push after release lands at index 0.

## Test plan
- Reset then idle, DEPTH=8 → level 0, val 0, almost_empty 1, data_out 0, flags 0.
- LIFO: push 0x11,0x22,0x33, then 3 pops → data_out 0x33, 0x22, 0x11, then 0 with val 0. A 4th pop sets underflow.
- FIFO (fifo_mode=1 while empty): push 10 values 0x01..0x0A with a pop interleaved after the 4th, DEPTH=8 → wrap correct, full at level 8, 0x0A push rejected, overflow 1, pop order 0x01..0x09.
- Simultaneous push+pop when full: LIFO top replaced by data_in with level stays 8. FIFO head 0x02 leaves while the new tail enters, level stays 8, overflow stays 0.
- Toggle fifo_mode with level 3 → mode unchanged. Drain to 0 → mode follows fifo_mode the same cycle.
- AF_LEVEL=6, AE_LEVEL=2: fill 0→8 → almost_empty drops at level 3, almost_full rises at 6. clear at level 5 → level 0 next cycle, flags preserved. err_clr → flags 0.
